race_stats_ctrl: RTL and testbench

// Game-statistics engine upstream of the BCD digit extractor. It turns rider controls and crash

---
 rtl/race_stats_ctrl_if.sv | 39 +++
 rtl/race_stats_ctrl.sv | 165 ++++++++++++++++
 tb/tb_race_stats_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/race_stats_ctrl_if.sv
// -----------------------------------------------------------------------------
// race_stats_ctrl_if
//
// Bundles the rider controls and the HUD statistics of race_stats_ctrl.
//
//   start     controller -> engine  start/restart request (level)
//   accel     controller -> engine  accelerate
//   brake     controller -> engine  brake, priority over accel
//   crash     controller -> engine  collision pulse
//   speed     engine -> controller  current speed (8 b)
//   score     engine -> controller  accumulated score (20 b)
//   lives     engine -> controller  remaining lives (3 b)
//   state     engine -> controller  00 IDLE, 01 RUN, 10 CRASH, 11 OVER
//   game_over engine -> controller  high while in OVER
//
// modport master : the side that drives the controls (game logic / bench)
// modport slave  : the statistics engine itself
// -----------------------------------------------------------------------------
interface race_stats_ctrl_if;
    logic        start;
    logic        accel;
    logic        brake;
    logic        crash;
    logic [7:0]  speed;
    logic [19:0] score;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic        game_over;

    modport master (
        output start, accel, brake, crash,
        input  speed, score, lives, state, game_over
    );

    modport slave (
        input  start, accel, brake, crash,
        output speed, score, lives, state, game_over
    );
endinterface

// File: rtl/race_stats_ctrl.sv
// -----------------------------------------------------------------------------
// race_stats_ctrl
//
// Game-statistics engine feeding the BCD digit extractor of the HUD. Converts
// rider controls and crash events into a binary speed and score, and owns the
// IDLE/RUN/CRASH/OVER state machine and the lives count.
//
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active-low
//   bus    race_stats_ctrl_if.slave (controls in, statistics out)
//
// Game time advances in ticks: a one-cycle pulse every TICK_DIV clocks, only
// while in RUN or CRASH. The tick counter restarts on every state change, so
// the first tick after entering a state lands TICK_DIV cycles later.
//
// Build option:
//   SPEED_BONUS_EN  when defined, a RUN tick whose pre-update speed is >= 150
//                   adds twice the speed to the score instead of once.
// -----------------------------------------------------------------------------
module race_stats_ctrl #(
    parameter int unsigned TICK_DIV    = 2_500_000,
    parameter logic [7:0]  MAX_SPEED   = 8'd199,
    parameter logic [7:0]  ACCEL_STEP  = 8'd2,
    parameter logic [7:0]  BRAKE_STEP  = 8'd6,
    parameter int unsigned CRASH_TICKS = 16,
    parameter logic [2:0]  START_LIVES = 3'd3
) (
    input  logic              clk,
    input  logic              reset,
    race_stats_ctrl_if.slave  bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CT_W  = (CRASH_TICKS > 1) ? $clog2(CRASH_TICKS) : 1;
    localparam logic [20:0] SCORE_MAX = 21'd999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10,
        OVER  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        speed_q, speed_d;
    logic [19:0]       score_q, score_d;
    logic [2:0]        lives_q, lives_d;
    logic              game_over_q, game_over_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [CT_W-1:0]   crash_cnt_q, crash_cnt_d;

    logic              timed;
    logic              tick;
    logic [8:0]        speed_up;
    logic [7:0]        speed_next;
    logic [20:0]       score_inc;
    logic [20:0]       score_sum;

    assign timed = (state_q == RUN) || (state_q == CRASH);
    assign tick  = timed && (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    // Speed after a RUN tick: brake beats accel, no controls means coasting.
    assign speed_up = {1'b0, speed_q} + {1'b0, ACCEL_STEP};

    always_comb begin
        speed_next = 8'd0;
        if (bus.brake) begin
            speed_next = (speed_q > BRAKE_STEP) ? (speed_q - BRAKE_STEP) : 8'd0;
        end else if (bus.accel) begin
            speed_next = (speed_up > {1'b0, MAX_SPEED}) ? MAX_SPEED : speed_up[7:0];
        end else begin
            speed_next = (speed_q != 8'd0) ? (speed_q - 8'd1) : 8'd0;
        end
    end

    // Score increment uses the speed held before this tick's update. The sum
    // is one bit wider than the score so the clamp sees any overshoot.
`ifdef SPEED_BONUS_EN
    assign score_inc = (speed_q >= 8'd150) ? {12'd0, speed_q, 1'b0} : {13'd0, speed_q};
`else
    assign score_inc = {13'd0, speed_q};
`endif
    assign score_sum = {1'b0, score_q} + score_inc;

    always_comb begin
        // NOTE: every _d gets its hold value first; a path that leaves one
        // unassigned in combinational logic would infer a latch.
        state_d     = state_q;
        speed_d     = speed_q;
        score_d     = score_q;
        lives_d     = lives_q;
        crash_cnt_d = crash_cnt_q;
        tick_cnt_d  = '0;
        if (timed) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = RUN;
                    speed_d = 8'd0;
                    score_d = 20'd0;
                    lives_d = START_LIVES;
                end
            end
            RUN: begin
                // A crash pre-empts a coincident tick: no score, no speed update.
                if (bus.crash) begin
                    state_d     = CRASH;
                    speed_d     = 8'd0;
                    lives_d     = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
                    crash_cnt_d = '0;
                end else if (tick) begin
                    speed_d = speed_next;
                    score_d = (score_sum > SCORE_MAX) ? SCORE_MAX[19:0] : score_sum[19:0];
                end
            end
            CRASH: begin
                if (tick) begin
                    if (crash_cnt_q == CT_W'(CRASH_TICKS - 1)) begin
                        state_d = (lives_q == 3'd0) ? OVER : RUN;
                    end else begin
                        crash_cnt_d = crash_cnt_q + CT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            speed_q     <= 8'd0;
            score_q     <= 20'd0;
            lives_q     <= START_LIVES;
            game_over_q <= 1'b0;
            tick_cnt_q  <= '0;
            crash_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values.
            state_q     <= state_d;
            speed_q     <= speed_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            tick_cnt_q  <= tick_cnt_d;
            crash_cnt_q <= crash_cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.speed     = speed_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_race_stats_ctrl.sv
// -----------------------------------------------------------------------------
// tb_race_stats_ctrl
//
// Bench for race_stats_ctrl with TICK_DIV=4 and CRASH_TICKS=2. Directed table
// of control phases with hand-derived expected statistics, an asynchronous
// reset check, a score saturation run, and a randomized phase compared every
// cycle against a behavioural game model.
// -----------------------------------------------------------------------------
module tb_race_stats_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int CRASH_TICKS = 2;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_CRASH = 2;
    localparam int S_OVER  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    race_stats_ctrl_if bus ();

    race_stats_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .CRASH_TICKS (CRASH_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural game model ----------------
    int m_state, m_cyc, m_speed, m_score, m_lives;

    task automatic model_reset();
        m_state = S_IDLE;
        m_cyc   = 0;
        m_speed = 0;
        m_score = 0;
        m_lives = 3;
    endtask

    // One clock of game rules; m_cyc counts clocks since the state was entered.
    task automatic model_step(input bit st, input bit ac, input bit br, input bit cr);
        bit tick;
        int nxt;
        int inc;
        tick = (m_state == S_RUN || m_state == S_CRASH) && (m_cyc % TICK_DIV == TICK_DIV - 1);
        nxt  = m_state;
        case (m_state)
            S_IDLE, S_OVER: begin
                if (st) begin
                    nxt = S_RUN; m_speed = 0; m_score = 0; m_lives = 3;
                end
            end
            S_RUN: begin
                if (cr) begin
                    nxt = S_CRASH; m_speed = 0; m_lives = m_lives - 1;
                end else if (tick) begin
                    inc = m_speed;
`ifdef SPEED_BONUS_EN
                    if (m_speed >= 150) inc = 2 * m_speed;
`endif
                    m_score = (m_score + inc > 999_999) ? 999_999 : m_score + inc;
                    if (br)      m_speed = (m_speed - 6 < 0) ? 0 : m_speed - 6;
                    else if (ac) m_speed = (m_speed + 2 > 199) ? 199 : m_speed + 2;
                    else         m_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1;
                end
            end
            default: begin
                if (m_cyc + 1 == CRASH_TICKS * TICK_DIV)
                    nxt = (m_lives == 0) ? S_OVER : S_RUN;
            end
        endcase
        m_cyc   = (nxt != m_state) ? 0 : m_cyc + 1;
        m_state = nxt;
    endtask

    // Drive controls for one clock; outputs are sampled on the falling edge.
    task automatic apply(input bit st, input bit ac, input bit br, input bit cr);
        bus.start = st;
        bus.accel = ac;
        bus.brake = br;
        bus.crash = cr;
        model_step(st, ac, br, cr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " speed"}, int'(bus.speed), m_speed);
        check({tag, " score"}, int'(bus.score), m_score);
        check({tag, " lives"}, int'(bus.lives), m_lives);
        check({tag, " state"}, int'(bus.state), m_state);
        check({tag, " game_over"}, int'(bus.game_over), (m_state == S_OVER) ? 1 : 0);
    endtask

    task automatic check_stats(input string tag, input int st, input int sp, input int sc, input int lv);
        check({tag, " state"}, int'(bus.state), st);
        check({tag, " speed"}, int'(bus.speed), sp);
        check({tag, " score"}, int'(bus.score), sc);
        check({tag, " lives"}, int'(bus.lives), lv);
        check({tag, " game_over"}, int'(bus.game_over), (st == S_OVER) ? 1 : 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit st, ac, br, cr;
        int cycles;
        int e_state, e_speed, e_score, e_lives;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit st, input bit ac, input bit br, input bit cr,
                                input int cycles, input int es, input int esp,
                                input int esc, input int el);
        vec_t v;
        v.st = st; v.ac = ac; v.br = br; v.cr = cr; v.cycles = cycles;
        v.e_state = es; v.e_speed = esp; v.e_score = esc; v.e_lives = el;
        tbl.push_back(v);
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.accel = 1'b0;
        bus.brake = 1'b0;
        bus.crash = 1'b0;
        model_reset();

        //   st ac br cr  cyc   state    speed  score   lives
        add(1, 0, 0, 0,    1, S_RUN,     0,      0, 3);
        add(0, 1, 0, 0,    4, S_RUN,     2,      0, 3);  // first tick
        add(0, 1, 0, 0,   40, S_RUN,    22,    110, 3);
        add(0, 1, 0, 0,  400, S_RUN,   199,  12089, 3);  // saturates at MAX
        add(0, 1, 1, 0,    4, S_RUN,   193,  12288, 3);  // brake beats accel
        add(0, 0, 0, 0,    4, S_RUN,   192,  12481, 3);  // coast
        add(0, 0, 1, 0,  128, S_RUN,     0,  15649, 3);
        add(0, 0, 1, 0,    4, S_RUN,     0,  15649, 3);  // brake floor
        add(0, 1, 0, 0,   20, S_RUN,    10,  15669, 3);
        add(0, 0, 0, 0,   40, S_RUN,     0,  15724, 3);  // coast 10..1 = 55
        add(1, 0, 0, 0,    4, S_RUN,     0,  15724, 3);  // start ignored in RUN
        add(0, 1, 0, 0,  160, S_RUN,    80,  17284, 3);
        add(0, 1, 0, 0,    3, S_RUN,    80,  17284, 3);
        add(0, 1, 0, 1,    1, S_CRASH,   0,  17284, 2);  // crash on tick cycle
        add(1, 1, 0, 1,    7, S_CRASH,   0,  17284, 2);  // crash/start ignored
        add(0, 0, 0, 0,    1, S_RUN,     0,  17284, 2);
        add(0, 1, 0, 0,    4, S_RUN,     2,  17284, 2);
        add(0, 0, 0, 1,    1, S_CRASH,   0,  17284, 1);
        add(0, 0, 0, 0,    8, S_RUN,     0,  17284, 1);
        add(0, 0, 0, 1,    1, S_CRASH,   0,  17284, 0);
        add(0, 1, 0, 0,    7, S_CRASH,   0,  17284, 0);
        add(0, 0, 0, 0,    1, S_OVER,    0,  17284, 0);
        add(0, 1, 0, 1,    5, S_OVER,    0,  17284, 0);  // frozen in OVER
        add(1, 0, 0, 0,    1, S_RUN,     0,      0, 3);  // restart
        add(0, 1, 0, 0,   80, S_RUN,    40,    380, 3);

        repeat (2) @(negedge clk);
        check_stats("reset", S_IDLE, 0, 0, 3);
        reset = 1'b1;
        @(negedge clk);
        check_stats("post-reset idle", S_IDLE, 0, 0, 3);

`ifndef SPEED_BONUS_EN
        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].cycles; c++)
                apply(tbl[i].st, tbl[i].ac, tbl[i].br, tbl[i].cr);
            check_stats($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_speed,
                        tbl[i].e_score, tbl[i].e_lives);
        end

        // Asynchronous reset mid-RUN at speed 40, away from any clock edge.
        #2 reset = 1'b0;
        #1 check_stats("async reset", S_IDLE, 0, 0, 3);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(0, 1, 0, 0);
        check_stats("after reset release", S_IDLE, 0, 0, 3);

        // Score saturation: 100 ramp ticks sum 9900, then +199 per tick.
        apply(1, 0, 0, 0);
        for (int c = 0; c < 5075 * TICK_DIV; c++) apply(0, 1, 0, 0);
        check_stats("pre-saturation", S_RUN, 199, 999_925, 3);
        for (int c = 0; c < TICK_DIV; c++) apply(0, 1, 0, 0);
        check_stats("saturation clamp", S_RUN, 199, 999_999, 3);
        for (int c = 0; c < 10 * TICK_DIV; c++) apply(0, 1, 0, 0);
        check_stats("saturation hold", S_RUN, 199, 999_999, 3);
`endif

        // Randomized play against the behavioural model.
        apply(1, 0, 0, 0);
        check_model("rand start");
        for (int c = 0; c < 4000; c++) begin
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0);
            check_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
